// File: rtl/demux8_pkg.sv
// Shared constants, FSM state encoding and a one-hot helper for the
// 8-channel demultiplexing scheduler.
package demux8_pkg;

    localparam int N_CH  = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    function automatic logic [N_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        logic [N_CH-1:0] vec;
        vec      = '0;
        vec[sel] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational wrapping search: first set bit of mask at or above start,
// wrapping from channel 7 back to channel 0.
module rr_pick8
    import demux8_pkg::*;
(
    input  logic [N_CH-1:0]  mask,
    input  logic [SEL_W-1:0] start,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = start;
        // Scan farthest offset first so the nearest enabled channel wins.
        for (int i = N_CH - 1; i >= 0; i--) begin
            cand = start + SEL_W'(i);
            if (mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/demux8_sched.sv
// One-word holding register that routes each accepted payload to one of
// eight channels, either addressed or round-robin over enabled channels.
module demux8_sched
    import demux8_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [N_CH-1:0]   chan_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    output logic [N_CH-1:0]   out_valid,
    input  logic [N_CH-1:0]   out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [7:0]        drop_cnt,
    output logic [SEL_W-1:0]  rr_ptr
);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [SEL_W-1:0]    dest_q, dest_d;
    logic [SEL_W-1:0]    rr_q, rr_d;
    logic [7:0]          drop_q, drop_d;

    logic                rr_found;
    logic [SEL_W-1:0]    rr_idx;
    logic                deliver;
    logic                accept;
    logic                loadable;
    logic [SEL_W-1:0]    sel;

    rr_pick8 u_pick (
        .mask  (chan_en),
        .start (rr_q),
        .found (rr_found),
        .idx   (rr_idx)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        dest_d    = dest_q;
        rr_d      = rr_q;
        drop_d    = drop_q;
        out_valid = '0;

        // Only the addressed channel's ready matters; reset blocks any handshake.
        deliver  = (state_q == ST_FULL) && out_ready[dest_q] && !rst;
        in_ready = !rst && ((state_q == ST_EMPTY) || deliver);
        accept   = in_valid && in_ready;

        if (mode) begin
            sel      = rr_idx;
            loadable = rr_found;
        end else begin
            sel      = in_sel;
            loadable = chan_en[in_sel];
        end

        if ((state_q == ST_FULL) && !rst) begin
            out_valid = sel_onehot(dest_q);
        end

        if (deliver) begin
            state_d = ST_EMPTY;
        end

        if (accept) begin
            if (loadable) begin
                state_d = ST_FULL;
                data_d  = in_data;
                dest_d  = sel;
                if (mode) begin
                    rr_d = sel + SEL_W'(1);
                end
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            dest_q  <= '0;
            rr_q    <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dest_q  <= dest_d;
            rr_q    <= rr_d;
            drop_q  <= drop_d;
        end
    end

    assign out_data = data_q;
    assign drop_cnt = drop_q;
    assign rr_ptr   = rr_q;

endmodule

// File: tb/tb_demux8_sched.sv
// Directed self-checking bench for demux8_sched with hand-computed expectations.
module tb_demux8_sched;

    logic       clk;
    logic       rst;
    logic       mode;
    logic [7:0] chan_en;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_sel;
    logic [7:0] out_valid;
    logic [7:0] out_ready;
    logic [7:0] out_data;
    logic [7:0] drop_cnt;
    logic [2:0] rr_ptr;

    int checks = 0;
    int errors = 0;

    demux8_sched #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .chan_en   (chan_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop_cnt  (drop_cnt),
        .rr_ptr    (rr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then step off the edge before driving/sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [7:0] seen_valid;
    logic [7:0] exp_oh [4];
    logic [2:0] exp_rr [4];

    initial begin
        rst       = 1'b1;
        mode      = 1'b0;
        chan_en   = 8'hFF;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_sel    = 3'd0;
        out_ready = 8'hFF;

        // Reset state
        tick();
        tick();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 8'h00);
        rst = 1'b0;
        settle();
        check("post_rst_in_ready", in_ready, 1'b1);
        check("post_rst_out_data", out_data, 8'h00);
        check("post_rst_drop", drop_cnt, 8'd0);
        check("post_rst_rr", rr_ptr, 3'd0);

        // Addressed routing with one-cycle latency
        in_valid = 1'b1;
        in_data  = 8'hA5;
        in_sel   = 3'd5;
        tick();
        in_valid = 1'b0;
        settle();
        check("addr_out_valid", out_valid, 8'h20);
        check("addr_out_data", out_data, 8'hA5);
        tick();
        check("addr_drained", out_valid, 8'h00);

        // Backpressure on channel 3
        out_ready = 8'hF7;
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        in_sel    = 3'd3;
        tick();
        in_data = 8'h77;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_out_valid", out_valid, 8'h08);
            check("bp_out_data", out_data, 8'h3C);
            tick();
        end
        out_ready = 8'hFF;
        settle();
        check("bp_release_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        settle();
        check("bp_new_valid", out_valid, 8'h08);
        check("bp_new_data", out_data, 8'h77);
        tick();
        check("bp_drained", out_valid, 8'h00);

        // Round-robin over mask 1000_0101 starting from pointer 0
        exp_oh[0] = 8'h01; exp_rr[0] = 3'd1;
        exp_oh[1] = 8'h04; exp_rr[1] = 3'd3;
        exp_oh[2] = 8'h80; exp_rr[2] = 3'd0;
        exp_oh[3] = 8'h01; exp_rr[3] = 3'd1;
        mode     = 1'b1;
        chan_en  = 8'b1000_0101;
        in_sel   = 3'd6;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'(8'hC0 + i);
            tick();
            check("rr_out_valid", out_valid, exp_oh[i]);
            check("rr_out_data", out_data, 8'(8'hC0 + i));
            check("rr_ptr", rr_ptr, exp_rr[i]);
        end
        in_valid = 1'b0;
        tick();

        // Round-robin drop with empty mask leaves the pointer alone
        chan_en  = 8'h00;
        in_valid = 1'b1;
        tick();
        check("rr_drop_cnt", drop_cnt, 8'd1);
        check("rr_drop_ptr", rr_ptr, 3'd1);
        check("rr_drop_valid", out_valid, 8'h00);

        // Addressed drops up to saturation
        mode       = 1'b0;
        seen_valid = 8'h00;
        for (int i = 0; i < 253; i++) begin
            tick();
            seen_valid = seen_valid | out_valid;
        end
        check("drop_254", drop_cnt, 8'd254);
        for (int i = 0; i < 47; i++) begin
            tick();
            seen_valid = seen_valid | out_valid;
        end
        check("drop_sat", drop_cnt, 8'd255);
        check("drop_never_valid", seen_valid, 8'h00);
        check("drop_in_ready", in_ready, 1'b1);
        check("drop_rr_hold", rr_ptr, 3'd1);

        // Streaming: one word per cycle
        chan_en   = 8'hFF;
        out_ready = 8'hFF;
        for (int i = 0; i < 16; i++) begin
            in_data = 8'(8'h10 + i);
            in_sel  = 3'(i);
            settle();
            check("stream_in_ready", in_ready, 1'b1);
            tick();
            check("stream_valid", out_valid, 8'(8'h01 << (i % 8)));
            check("stream_data", out_data, 8'(8'h10 + i));
        end
        in_valid = 1'b0;
        tick();
        check("stream_drained", out_valid, 8'h00);

        // Held word ignores later chan_en/mode changes
        out_ready = 8'h00;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        in_sel    = 3'd6;
        tick();
        in_valid = 1'b0;
        chan_en  = 8'h00;
        mode     = 1'b1;
        settle();
        check("hold_valid", out_valid, 8'h40);
        out_ready = 8'h40;
        tick();
        check("hold_delivered", out_valid, 8'h00);

        // Reset while FULL discards the word
        mode      = 1'b0;
        chan_en   = 8'hFF;
        out_ready = 8'h00;
        in_valid  = 1'b1;
        in_data   = 8'h99;
        in_sel    = 3'd2;
        tick();
        in_valid = 1'b0;
        settle();
        check("rf_loaded", out_valid, 8'h04);
        rst = 1'b1;
        settle();
        check("rf_rst_ready", in_ready, 1'b0);
        tick();
        check("rf_rst_valid", out_valid, 8'h00);
        check("rf_rst_ready2", in_ready, 1'b0);
        rst = 1'b0;
        settle();
        check("rf_after_valid", out_valid, 8'h00);
        check("rf_after_drop", drop_cnt, 8'd0);
        check("rf_after_rr", rr_ptr, 3'd0);
        check("rf_after_data", out_data, 8'h00);
        check("rf_after_ready", in_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
